// File: rtl/lfsr_prog_sequencer.sv
// lfsr_prog_sequencer: fetch/decode/execute controller for an 8-bit Galois LFSR and its pattern memory
module lfsr_prog_sequencer #(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [IMEM_AW-1:0] a,
    input  logic [13:0]        rd,
    output logic               mem_we,
    output logic               mem_re,
    output logic [DMEM_AW-1:0] r_addr,
    output logic [7:0]         mem_wdata,
    input  logic [7:0]         mem_rdata,
    output logic [0:7]         Q,
    output logic [6:0]         tap,
    output logic [3:0]         hd,
    output logic               busy,
    output logic               halted,
    output logic               illegal
);
    localparam logic [5:0] OP_CFG   = 6'b000001;
    localparam logic [5:0] OP_INIT  = 6'b000010;
    localparam logic [5:0] OP_RUN   = 6'b000011;
    localparam logic [5:0] OP_BATCH = 6'b001011;
    localparam logic [5:0] OP_STORE = 6'b000100;
    localparam logic [5:0] OP_LOAD  = 6'b000101;
    localparam logic [5:0] OP_IADDR = 6'b000110;
    localparam logic [5:0] OP_AADDR = 6'b000111;
    localparam logic [5:0] OP_SHD   = 6'b001001;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_RUN, S_LWAIT, S_HALT} state_t;

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [13:0]        ir_q, ir_d;
    logic [0:7]         q_q, q_d;
    logic [6:0]         tap_q, tap_d;
    logic [DMEM_AW-1:0] addr_q, addr_d;
    logic [3:0]         hd_q, hd_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [4:0]         runs_q, runs_d;
    logic               ill_q, ill_d;
    logic               we, re;
    logic [0:7]         n;
    logic [5:0]         op;
    logic [7:0]         imm;

    assign op  = ir_q[13:8];
    assign imm = ir_q[7:0];

    // Galois step: Q[7] re-enters at Q[0] and is folded into the tapped stages
    always_comb begin
        n[0] = q_q[7];
        for (int k = 1; k < 8; k++) n[k] = q_q[k-1] ^ (tap_q[7-k] & q_q[7]);
    end

    // next-state, datapath updates and memory strobes
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        q_d       = q_q;
        tap_d     = tap_q;
        addr_d    = addr_q;
        hd_d      = hd_q;
        cnt_d     = cnt_q;
        runs_d    = runs_q;
        ill_d     = ill_q;
        we        = 1'b0;
        re        = 1'b0;
        mem_wdata = q_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    ill_d   = 1'b0;
                end
            end
            S_FETCH: begin
                ir_d    = rd;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + 1'b1;
                case (op)
                    OP_CFG: begin
                        if (imm[7]) ill_d = 1'b1;
                        else tap_d = imm[6:0];
                    end
                    OP_INIT:  q_d = imm;
                    OP_RUN, OP_BATCH: begin
                        if (op == OP_RUN) runs_d = (runs_q == 5'd31) ? runs_q : runs_q + 1'b1;
                        if (imm != 8'd0) begin
                            state_d = S_RUN;
                            cnt_d   = imm;
                            pc_d    = pc_q;
                        end
                    end
                    OP_STORE: we = 1'b1;
                    OP_LOAD: begin
                        re      = 1'b1;
                        state_d = S_LWAIT;
                        pc_d    = pc_q;
                    end
                    OP_IADDR: addr_d = DMEM_AW'(imm);
                    OP_AADDR: addr_d = addr_q + DMEM_AW'(imm);
                    OP_SHD: begin
                        we        = 1'b1;
                        mem_wdata = {4'b0, hd_q};
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: ill_d = 1'b1;
                endcase
            end
            S_RUN: begin
                q_d   = n;
                hd_d  = 4'($countones(q_q ^ n));
                cnt_d = cnt_q - 1'b1;
                if (op == OP_BATCH) begin
                    we        = 1'b1;
                    mem_wdata = n;
                    addr_d    = addr_q + 1'b1;
                end
                if (cnt_q == 8'd1) begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + 1'b1;
                end
            end
            S_LWAIT: begin
                q_d     = mem_rdata;
                pc_d    = pc_q + 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // architectural registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            q_q     <= '0;
            tap_q   <= '0;
            addr_q  <= '0;
            hd_q    <= '0;
            cnt_q   <= '0;
            runs_q  <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            q_q     <= q_d;
            tap_q   <= tap_d;
            addr_q  <= addr_d;
            hd_q    <= hd_d;
            cnt_q   <= cnt_d;
            runs_q  <= runs_d;
            ill_q   <= ill_d;
        end
    end

    // strobes are suppressed while reset is held so an in-flight write is dropped
    assign mem_we  = rst_n & we;
    assign mem_re  = rst_n & re;
    assign a       = pc_q;
    assign r_addr  = addr_q;
    assign Q       = q_q;
    assign tap     = tap_q;
    assign hd      = hd_q;
    assign illegal = ill_q;
    assign busy    = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_RUN) || (state_q == S_LWAIT);
    assign halted  = (state_q == S_HALT);
endmodule
